// File: rtl/change_dispenser.sv
// change_dispenser: returns a money total as a sequence of coins, always
// emitting the largest denomination that still fits, one coin per cycle.
// Any residual below the smallest coin is left on o_remaining.
// Optional feature: define COIN_COUNT_EN to add o_coin_count, a saturating
// count of coins emitted by the current transaction.
module change_dispenser #(
    parameter int K_NUM_COINS  = 3,
    parameter int K_TOTAL_BITS = 31,
    parameter int COIN_VAL0    = 100,
    parameter int COIN_VAL1    = 500,
    parameter int COIN_VAL2    = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_start,
    input  logic [K_TOTAL_BITS-1:0] i_return_total,
    output logic [K_NUM_COINS-1:0]  o_return_coin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [K_TOTAL_BITS-1:0] o_remaining
`ifdef COIN_COUNT_EN
    ,
    output logic [15:0]             o_coin_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_t;

    localparam logic [K_TOTAL_BITS-1:0] MIN_COIN = K_TOTAL_BITS'(COIN_VAL0);

    state_t                  state;
    state_t                  state_next;
    logic [K_TOTAL_BITS-1:0] remaining_next;
    logic [K_NUM_COINS-1:0]  coin_next;
    logic                    done_next;
    logic [K_TOTAL_BITS-1:0] cand_val;
    logic [K_TOTAL_BITS-1:0] sel_val;

    // Denomination value by index; indices beyond the defined coins are unused.
    function automatic logic [K_TOTAL_BITS-1:0] coin_value(input int unsigned idx);
        case (idx)
            0:       return K_TOTAL_BITS'(COIN_VAL0);
            1:       return K_TOTAL_BITS'(COIN_VAL1);
            2:       return K_TOTAL_BITS'(COIN_VAL2);
            default: return '0;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next coin, next residual and done pulse.
    always_comb begin
        state_next     = state;
        remaining_next = o_remaining;
        coin_next      = '0;
        done_next      = 1'b0;
        cand_val       = '0;
        sel_val        = '0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    remaining_next = i_return_total;
                    state_next     = (i_return_total >= MIN_COIN) ? DISPENSE : DONE;
                end
            end
            DISPENSE: begin
                // Denominations ascend, so the last fitting candidate is the largest.
                for (int unsigned i = 0; i < K_NUM_COINS; i++) begin
                    cand_val = coin_value(i);
                    if ((cand_val != '0) && (cand_val <= o_remaining)) begin
                        sel_val      = cand_val;
                        coin_next    = '0;
                        coin_next[i] = 1'b1;
                    end
                end
                remaining_next = o_remaining - sel_val;
                if (remaining_next < MIN_COIN) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs: coin, residual and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_return_coin <= '0;
            o_remaining   <= '0;
            o_done        <= 1'b0;
        end else begin
            o_return_coin <= coin_next;
            o_remaining   <= remaining_next;
            o_done        <= done_next;
        end
    end

    // Busy whenever a transaction is in flight.
    always_comb begin
        o_busy = (state != IDLE);
    end

`ifdef COIN_COUNT_EN
    // Per-transaction coin counter, cleared on each accepted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_coin_count <= '0;
        end else if ((state == IDLE) && i_start) begin
            o_coin_count <= '0;
        end else if ((|coin_next) && (o_coin_count != 16'hFFFF)) begin
            o_coin_count <= o_coin_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
module tb_change_dispenser;

    logic        clk;
    logic        reset_n;
    logic        i_start;
    logic [30:0] i_return_total;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_remaining;
`ifdef COIN_COUNT_EN
    logic [15:0] o_coin_count;
`endif

    int unsigned n_checks;
    int unsigned n_fails;

    change_dispenser #(
        .K_NUM_COINS (3),
        .K_TOTAL_BITS(31),
        .COIN_VAL0   (100),
        .COIN_VAL1   (500),
        .COIN_VAL2   (1000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_return_total(i_return_total),
        .o_return_coin (o_return_coin),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_remaining   (o_remaining)
`ifdef COIN_COUNT_EN
        ,
        .o_coin_count  (o_coin_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse i_start for exactly one sampling edge.
    task automatic start_txn(input logic [30:0] total);
        i_start        = 1'b1;
        i_return_total = total;
        step();
        i_start        = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] coin, input logic busy,
                              input logic done, input logic [30:0] rem);
        check({tag, ".coin"}, 32'(o_return_coin), 32'(coin));
        check({tag, ".busy"}, 32'(o_busy), 32'(busy));
        check({tag, ".done"}, 32'(o_done), 32'(done));
        check({tag, ".rem"}, 32'(o_remaining), 32'(rem));
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        reset_n        = 1'b0;
        i_start        = 1'b0;
        i_return_total = '0;
        #1;
        expect_out("reset", 3'b000, 1'b0, 1'b0, 31'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // 1600 -> 1000, 500, 100, then done with nothing left.
        start_txn(31'd1600);
        expect_out("t1600.c0", 3'b000, 1'b1, 1'b0, 31'd1600);
        step(); expect_out("t1600.c1", 3'b100, 1'b1, 1'b0, 31'd600);
        step(); expect_out("t1600.c2", 3'b010, 1'b1, 1'b0, 31'd100);
        step(); expect_out("t1600.c3", 3'b001, 1'b1, 1'b0, 31'd0);
        step(); expect_out("t1600.c4", 3'b000, 1'b0, 1'b1, 31'd0);
`ifdef COIN_COUNT_EN
        check("t1600.count", 32'(o_coin_count), 32'd3);
`endif
        step(); expect_out("t1600.c5", 3'b000, 1'b0, 1'b0, 31'd0);

        // Zero -> straight to DONE, busy for one cycle only.
        start_txn(31'd0);
        expect_out("t0.c0", 3'b000, 1'b1, 1'b0, 31'd0);
`ifdef COIN_COUNT_EN
        check("t0.count_cleared", 32'(o_coin_count), 32'd0);
`endif
        step(); expect_out("t0.c1", 3'b000, 1'b0, 1'b1, 31'd0);
        step(); expect_out("t0.c2", 3'b000, 1'b0, 1'b0, 31'd0);

        // 250 -> two 100 coins, residual 50 held in IDLE.
        start_txn(31'd250);
        expect_out("t250.c0", 3'b000, 1'b1, 1'b0, 31'd250);
        step(); expect_out("t250.c1", 3'b001, 1'b1, 1'b0, 31'd150);
        step(); expect_out("t250.c2", 3'b001, 1'b1, 1'b0, 31'd50);
        step(); expect_out("t250.c3", 3'b000, 1'b0, 1'b1, 31'd50);
        step(); expect_out("t250.c4", 3'b000, 1'b0, 1'b0, 31'd50);
        step(); expect_out("t250.c5", 3'b000, 1'b0, 1'b0, 31'd50);

        // Exact smallest coin boundary: 100 -> one coin.
        start_txn(31'd100);
        step(); expect_out("t100.c1", 3'b001, 1'b1, 1'b0, 31'd0);
        step(); expect_out("t100.c2", 3'b000, 1'b0, 1'b1, 31'd0);

        // Just below smallest coin: 99 -> no coin, residual 99.
        start_txn(31'd99);
        step(); expect_out("t99.c1", 3'b000, 1'b0, 1'b1, 31'd99);

        // 2000 with a second request during DISPENSE -> ignored.
        start_txn(31'd2000);
        i_start        = 1'b1;
        i_return_total = 31'd700;
        step();
        i_start        = 1'b0;
        expect_out("t2000.c1", 3'b100, 1'b1, 1'b0, 31'd1000);
        step(); expect_out("t2000.c2", 3'b100, 1'b1, 1'b0, 31'd0);
        step(); expect_out("t2000.c3", 3'b000, 1'b0, 1'b1, 31'd0);
        step(); expect_out("t2000.c4", 3'b000, 1'b0, 1'b0, 31'd0);

        // 3000 with reset mid-dispense -> outputs cleared at once, no done later.
        start_txn(31'd3000);
        step(); expect_out("t3000.c1", 3'b100, 1'b1, 1'b0, 31'd2000);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("t3000.rst", 3'b000, 1'b0, 1'b0, 31'd0);
`ifdef COIN_COUNT_EN
        check("t3000.count_rst", 32'(o_coin_count), 32'd0);
`endif
        step();
        reset_n = 1'b1;
        step(); expect_out("t3000.post1", 3'b000, 1'b0, 1'b0, 31'd0);
        step(); expect_out("t3000.post2", 3'b000, 1'b0, 1'b0, 31'd0);

        // First edge after release accepts a request: 1500 -> 1000, 500.
        start_txn(31'd1500);
        expect_out("t1500.c0", 3'b000, 1'b1, 1'b0, 31'd1500);
        step(); expect_out("t1500.c1", 3'b100, 1'b1, 1'b0, 31'd500);
        step(); expect_out("t1500.c2", 3'b010, 1'b1, 1'b0, 31'd0);
        step(); expect_out("t1500.c3", 3'b000, 1'b0, 1'b1, 31'd0);
`ifdef COIN_COUNT_EN
        check("t1500.count", 32'(o_coin_count), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter K_NUM_COINS, default 3, number of coin denominations.
REQ-002 SHALL have parameter K_TOTAL_BITS, default 31, width of money totals.
REQ-003 SHALL have parameters COIN_VAL0/COIN_VAL1/COIN_VAL2, defaults 100/500/1000, denomination values; COIN_VAL0 is the smallest and COIN_VAL2 the largest.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_start  input  1  one-cycle request to return change (driven when wait time expires or return is triggered).
REQ-007 SHALL have port i_return_total  input  K_TOTAL_BITS  amount to return, sampled with i_start.
REQ-008 SHALL have port o_return_coin  output  K_NUM_COINS  registered one-hot coin emitted this cycle (bit i = COIN_VALi).
REQ-009 SHALL have port o_busy  output  1  high while not IDLE.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse when dispensing completes.
REQ-011 SHALL have port o_remaining  output  K_TOTAL_BITS  amount still owed; after completion, undispensable residual.

Function
REQ-012 SHALL implement states IDLE, DISPENSE, DONE.
REQ-013 IDLE: on i_start=1 with i_return_total >= COIN_VAL0, SHALL latch i_return_total into o_remaining and enter DISPENSE.
REQ-014 IDLE: on i_start=1 with i_return_total < COIN_VAL0, SHALL latch it into o_remaining and enter DONE with no coin emitted.
REQ-015 DISPENSE: each cycle SHALL select the largest COIN_VALi <= o_remaining, assert only bit i of o_return_coin for one cycle, and subtract COIN_VALi from o_remaining.
REQ-016 DISPENSE: SHALL enter DONE on the same edge that leaves o_remaining < COIN_VAL0.
REQ-017 DONE: SHALL assert o_done for exactly one cycle, hold o_return_coin at 0, then return to IDLE.
REQ-018 Latency: i_start sampled at edge N SHALL produce the first coin on o_return_coin after edge N+1; an amount needing k coins SHALL give o_done after edge N+k+1.
REQ-019 SHALL ignore i_start while in DISPENSE or DONE; the latched amount is not altered.
REQ-020 o_return_coin SHALL be 0 in every cycle not emitting a coin; never more than one bit set.
REQ-021 Subtraction SHALL never underflow; o_remaining is unsigned, K_TOTAL_BITS wide.
REQ-022 Residual below COIN_VAL0 SHALL remain on o_remaining until the next accepted i_start.

Reset
REQ-023 reset_n=0 SHALL asynchronously force state IDLE, o_return_coin=0, o_busy=0, o_done=0, o_remaining=0.
REQ-024 Reset asserted mid-DISPENSE SHALL abandon the transaction; no o_done pulse follows reset release.
REQ-025 First i_start accepted SHALL be on the first rising edge with reset_n=1.

Configuration
REQ-026 With macro COIN_COUNT_EN defined, SHALL add output o_coin_count (16 bits), zeroed by reset and on each accepted i_start, incremented once per emitted coin, saturating at 16'hFFFF.
REQ-027 Without COIN_COUNT_EN, o_coin_count port and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 i_start with total 1600 -> coins 1000, 500, 100 on three consecutive cycles, o_done next cycle, o_remaining=0.
REQ-029 i_start with total 0 -> no coin, o_done one cycle after start, o_busy high one cycle.
REQ-030 i_start with total 250 -> coins 100, 100, o_done, o_remaining=50 held in IDLE.
REQ-031 Start 2000, second i_start with 700 on first DISPENSE cycle -> ignored; exactly two 1000 coins emitted.
REQ-032 Start 3000, reset_n low after first coin -> all outputs 0 immediately, state IDLE, no o_done after release.
REQ-033 With COIN_COUNT_EN: total 1600 -> o_coin_count=3 at o_done; next start clears it to 0.
